// File: rtl/opnd_ser_pkg.sv
// Shared definitions for the operand serializer: FSM state encoding and default width.
package opnd_ser_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFlush = 2'd2
  } state_e;

endpackage

// File: rtl/opnd_ser.sv
// Serializes an operand pair LSB first into a downstream bit-serial adder, then emits one
// carry-out flush slot with zero operands so the adder's carry is left cleared.
module opnd_ser
  import opnd_ser_pkg::*;
#(
  parameter int unsigned W = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         x,
  output logic         y,
  output logic         bit_valid,
  output logic         first,
  output logic         last,
  output logic         flush
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    sha_q, sha_d;
  logic [W-1:0]    shb_q, shb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      sha_q   <= '0;
      shb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      cnt_q   <= cnt_d;
    end
  end

  // start is only looked at in idle; requests during a frame are dropped, not queued.
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sha_d = sha_q >> 1;
        shb_d = shb_q >> 1;
        if (cnt_q == CntLast) begin
          // Hold the counter on the last bit so it never wraps inside a frame.
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on registered state, never on start/a/b directly.
  always_comb begin
    ready     = 1'b0;
    x         = 1'b0;
    y         = 1'b0;
    bit_valid = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
      end
      StShift: begin
        x         = sha_q[0];
        y         = shb_q[0];
        bit_valid = 1'b1;
        first     = (cnt_q == '0);
        last      = (cnt_q == CntLast);
      end
      StFlush: begin
        flush = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_opnd_ser.sv
// Directed bench for opnd_ser feeding a bit-serial adder model and a sum collector.
module tb_opnd_ser;

  localparam int W = 8;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         x;
  logic         y;
  logic         bit_valid;
  logic         first;
  logic         last;
  logic         flush;

  int n_cmp = 0;
  int n_err = 0;

  opnd_ser #(
    .W(W)
  ) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .bit_valid (bit_valid),
    .first     (first),
    .last      (last),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial adder: sum bit is combinational, carry registered; shares rst_b with the DUT.
  logic         carry;
  logic         s;
  logic         flush_bit;
  logic [W-1:0] sum_acc;

  assign s = x ^ y ^ carry;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      carry     <= 1'b0;
      sum_acc   <= '0;
      flush_bit <= 1'b0;
    end else begin
      if (bit_valid || flush) begin
        carry <= (x & y) | (carry & (x ^ y));
      end
      if (bit_valid) begin
        sum_acc <= {s, sum_acc[W-1:1]};
      end
      if (flush) begin
        flush_bit <= s;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {ready, x, y, bit_valid, first, last, flush};
  endfunction

  // Called at a negedge in idle; returns at the negedge of the first SHIFT cycle.
  task automatic start_frame(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sample_frame(input int inj_at, input logic inj_start,
                              input logic [W-1:0] ia, input logic [W-1:0] ib,
                              output logic [W-1:0] xs, output logic [W-1:0] ys,
                              output int fpos, output int lpos, output int nvalid,
                              output logic fl_ok);
    xs     = '0;
    ys     = '0;
    fpos   = -1;
    lpos   = -1;
    nvalid = 0;
    for (int i = 0; i < W; i++) begin
      xs[i] = x;
      ys[i] = y;
      nvalid += int'(bit_valid);
      if (first) fpos = i;
      if (last) lpos = i;
      if (i == inj_at) begin
        start = inj_start;
        a     = ia;
        b     = ib;
      end
      @(negedge clk);
      if (i == inj_at) start = 1'b0;
    end
    fl_ok = flush & ~bit_valid & ~x & ~y & ~ready;
    @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic [W-1:0] exp_sum,
                               input logic exp_fb, input int inj_at, input logic inj_start,
                               input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [W-1:0] xs, ys;
    int           fpos, lpos, nvalid;
    logic         fl_ok;
    start_frame(av, bv);
    sample_frame(inj_at, inj_start, ia, ib, xs, ys, fpos, lpos, nvalid, fl_ok);
    chk({tag, "_xstream"}, 32'(xs), 32'(av));
    chk({tag, "_ystream"}, 32'(ys), 32'(bv));
    chk({tag, "_sum"}, 32'(sum_acc), 32'(exp_sum));
    chk({tag, "_flushbit"}, 32'(flush_bit), 32'(exp_fb));
    chk({tag, "_nvalid"}, 32'(nvalid), 32'(W));
    chk({tag, "_firstpos"}, 32'(fpos), 32'd0);
    chk({tag, "_lastpos"}, 32'(lpos), 32'(W - 1));
    chk({tag, "_flushslot"}, 32'(fl_ok), 32'd1);
    chk({tag, "_idle_after"}, 32'(outs()), 32'b1000000);
  endtask

  initial begin
    logic [31:0] rdy_mask, fst_mask, lst_mask;
    rst_b = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    chk("reset_outs", 32'(outs()), 32'b1000000);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(outs()), 32'b1000000);

    // 5 + 3: streams 1,0,1,0,... / 1,1,0,...; sum 0x08, no carry out
    run_and_check("add_05_03", 8'h05, 8'h03, 8'h08, 1'b0, -1, 1'b0, 8'h00, 8'h00);
    // Carry out into the flush slot, then a frame proving the carry was cleared
    run_and_check("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, -1, 1'b0, 8'h00, 8'h00);
    run_and_check("add_01_01", 8'h01, 8'h01, 8'h02, 1'b0, -1, 1'b0, 8'h00, 8'h00);

    // start held high: accepts at cycles 0,10,20; first at 1,11,21; last at 8,18,28
    rdy_mask = '0;
    fst_mask = '0;
    lst_mask = '0;
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    for (int i = 0; i < 30; i++) begin
      rdy_mask[i] = ready;
      fst_mask[i] = first;
      lst_mask[i] = last;
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_ready_mask", rdy_mask, 32'h0010_0401);
    chk("held_first_mask", fst_mask, 32'h0020_0802);
    chk("held_last_mask", lst_mask, 32'h1004_0100);
    chk("held_sum", 32'(sum_acc), 32'h33);

    // start pulsed mid-frame with different operands must be dropped
    run_and_check("ign_start", 8'h5A, 8'h3C, 8'h96, 1'b0, 2, 1'b1, 8'hFF, 8'hFF);
    @(negedge clk);
    chk("ign_no_queue", 32'(outs()), 32'b1000000);

    // Operands changed right after accept must not leak into the frame
    run_and_check("late_ab", 8'h96, 8'h69, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 8'hFF);

    // Asynchronous reset after the 3rd bit
    start_frame(8'hC3, 8'h3C);
    repeat (3) @(negedge clk);
    chk("rst_pre_valid", 32'(bit_valid), 32'd1);
    #1 rst_b = 1'b0;
    #1;
    chk("rst_mid_outs", 32'(outs()), 32'b1000000);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_no_flush", 32'(outs()), 32'b1000000);
    run_and_check("after_rst", 8'hC3, 8'h3C, 8'hFF, 1'b0, -1, 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
